// File: rtl/arrow_pkg.sv
// Shared types and constants for the per-lane arrow position controllers.
package arrow_pkg;

  localparam int SCREEN_H = 720;
  localparam int SPRITE_H = 100;

  localparam int X_POS_DEF       = 590;
  localparam int START_Y_DEF     = SCREEN_H - SPRITE_H;
  localparam int TARGET_Y_DEF    = 40;
  localparam int WINDOW_DEF      = 16;
  localparam int HOLD_FRAMES_DEF = 8;
  localparam int TICK_LINE_DEF   = SCREEN_H;

  typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

  typedef enum logic [1:0] {GRADE_NONE, GRADE_GOOD, GRADE_PERFECT} grade_t;

  // Distance is taken after ordering the operands so it never wraps.
  function automatic grade_t grade_of(input logic [9:0] y,
                                      input logic [9:0] target,
                                      input logic [10:0] window);
    logic [10:0] dy;
    if (y >= target) dy = {1'b0, y} - {1'b0, target};
    else             dy = {1'b0, target} - {1'b0, y};
    if (dy <= (window >> 2)) return GRADE_PERFECT;
    else if (dy <= window)   return GRADE_GOOD;
    else                     return GRADE_NONE;
  endfunction

endpackage

// File: rtl/arrow_scroll_if.sv
// Video timing, player controls and sprite position bundle for one arrow lane.
interface arrow_scroll_if;
  import arrow_pkg::*;

  // No backpressure anywhere: spawn_in/hit_in are single-cycle requests taken
  // when the controller can act on them, hit_out/miss_out are single-cycle
  // pulses, and grade_out stays valid from one hit_out until the next.
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        spawn_in;
  logic [3:0]  speed_in;
  logic        hit_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        active_out;
  logic        hit_out;
  logic [1:0]  grade_out;
  logic        miss_out;
  state_t      state;

  modport master (
    output hcount_in, vcount_in, spawn_in, speed_in, hit_in,
    input  x_out, y_out, active_out, hit_out, grade_out, miss_out, state
  );

  modport slave (
    input  hcount_in, vcount_in, spawn_in, speed_in, hit_in,
    output x_out, y_out, active_out, hit_out, grade_out, miss_out, state
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Registered once-per-frame pulse on the first pixel of a chosen blanking line.
module frame_tick_gen #(
  parameter int TICK_LINE = arrow_pkg::TICK_LINE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        tick
);

  // hcount is 0 for exactly one pixel per line, so this fires once per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= (hcount == 11'd0) && (vcount == 10'(TICK_LINE));
  end

endmodule

// File: rtl/arrow_scroll_ctrl.sv
// Spawns, scrolls and grades one arrow; position only moves on the blanking tick.
module arrow_scroll_ctrl
  import arrow_pkg::*;
#(
  parameter int X_POS       = X_POS_DEF,
  parameter int START_Y     = START_Y_DEF,
  parameter int TARGET_Y    = TARGET_Y_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int TICK_LINE   = TICK_LINE_DEF
) (
  input  logic           pixel_clk_in,
  input  logic           rst_in,
  arrow_scroll_if.slave  bus
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic          tick;
  state_t        state_r;
  logic [9:0]    y_r;
  logic [3:0]    speed_r;
  logic [HW-1:0] hold_r;
  logic          active_r;
  logic          hit_r;
  logic          miss_r;
  grade_t        grade_r;
  grade_t        grade_now;

  frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_tick (
    .clk    (pixel_clk_in),
    .rst    (rst_in),
    .hcount (bus.hcount_in),
    .vcount (bus.vcount_in),
    .tick   (tick)
  );

  assign grade_now = grade_of(y_r, 10'(TARGET_Y), 11'(WINDOW));

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r  <= IDLE;
      y_r      <= 10'(START_Y);
      speed_r  <= 4'd0;
      hold_r   <= '0;
      active_r <= 1'b0;
      hit_r    <= 1'b0;
      miss_r   <= 1'b0;
      grade_r  <= GRADE_NONE;
    end else begin
      hit_r  <= 1'b0;
      miss_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.spawn_in) begin
            state_r  <= SCROLL;
            y_r      <= 10'(START_Y);
            speed_r  <= (bus.speed_in == 4'd0) ? 4'd1 : bus.speed_in;
            active_r <= 1'b1;
          end
        end
        SCROLL: begin
          // A graded press wins over the tick: the arrow freezes where it was hit.
          if (bus.hit_in && grade_now != GRADE_NONE) begin
            hit_r   <= 1'b1;
            grade_r <= grade_now;
            hold_r  <= HW'(HOLD_FRAMES);
            state_r <= HOLD;
          end else if (tick) begin
            if (y_r < {6'd0, speed_r}) begin
              miss_r   <= 1'b1;
              state_r  <= IDLE;
              active_r <= 1'b0;
            end else begin
              y_r <= y_r - {6'd0, speed_r};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_r <= HW'(1)) begin
              hold_r   <= '0;
              state_r  <= IDLE;
              active_r <= 1'b0;
            end else begin
              hold_r <= hold_r - HW'(1);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out      = 11'(X_POS);
  assign bus.y_out      = y_r;
  assign bus.active_out = active_r;
  assign bus.hit_out    = hit_r;
  assign bus.grade_out  = grade_r;
  assign bus.miss_out   = miss_r;
  assign bus.state      = state_r;

endmodule

// File: tb/tb_arrow_scroll_ctrl.sv
// Self-checking bench for arrow_scroll_ctrl: hit/miss events go through a scoreboard queue.
module tb_arrow_scroll_ctrl;
  import arrow_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arrow_scroll_if bus();

  arrow_scroll_ctrl dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;
  // Event word: {hit_out, miss_out, grade_out, y_out}
  logic [13:0] exp_q[$];
  logic [1:0]  exp_grade = 2'd0;
  logic [13:0] mon_got;
  logic [13:0] mon_exp;

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.hit_out === 1'b1 || bus.miss_out === 1'b1)) begin
      mon_got = {bus.hit_out, bus.miss_out, bus.grade_out, bus.y_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h, expected no event", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL event: got %h, expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hcount_in = 11'd3;
    bus.vcount_in = 10'd100;
  endtask

  task automatic frame(input logic with_hit = 1'b0);
    bus.hcount_in = 11'd0;
    bus.vcount_in = 10'd720;
    step();
    idle_inputs();
    bus.hit_in = with_hit;
    step();
    bus.hit_in = 1'b0;
    step();
  endtask

  task automatic spawn(input logic [3:0] s);
    bus.spawn_in = 1'b1;
    bus.speed_in = s;
    step();
    bus.spawn_in = 1'b0;
  endtask

  task automatic press();
    bus.hit_in = 1'b1;
    step();
    bus.hit_in = 1'b0;
    step();
  endtask

  task automatic push_hit(input logic [1:0] g, input logic [9:0] y);
    exp_q.push_back({1'b1, 1'b0, g, y});
    exp_grade = g;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if (bus.x_out !== 11'd590 || bus.y_out !== 10'd620 || bus.active_out !== 1'b0 ||
        bus.hit_out !== 1'b0 || bus.grade_out !== 2'd0 || bus.miss_out !== 1'b0 ||
        bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset_values: x=%0d y=%0d act=%0b hit=%0b grade=%0d miss=%0b, expected 590 620 0 0 0 0",
               bus.x_out, bus.y_out, bus.active_out, bus.hit_out, bus.grade_out, bus.miss_out);
    end
    rst = 1'b0;
    step();
    press();
    frame();
    checks++;
    if (bus.y_out !== 10'd620 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL idle_no_move: y=%0d state=%0d, expected y=620 IDLE", bus.y_out, bus.state);
    end
  endtask

  task automatic test_scroll();
    logic [9:0] ey;
    spawn(4'd10);
    checks++;
    if (bus.y_out !== 10'd620 || bus.active_out !== 1'b1 || bus.state !== SCROLL) begin
      errors++;
      $display("FAIL spawn: y=%0d act=%0b, expected y=620 act=1", bus.y_out, bus.active_out);
    end
    ey = 10'd620;
    for (int i = 0; i < 3; i++) begin
      frame();
      ey = ey - 10'd10;
      checks++;
      if (bus.y_out !== ey || bus.active_out !== 1'b1) begin
        errors++;
        $display("FAIL scroll_step: y=%0d act=%0b, expected y=%0d act=1", bus.y_out, bus.active_out, ey);
      end
    end
  endtask

  task automatic test_reset_mid_scroll();
    run_frames(29);
    checks++;
    if (bus.y_out !== 10'd300) begin
      errors++;
      $display("FAIL pre_reset_y: y=%0d, expected 300", bus.y_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.y_out !== 10'd620 || bus.active_out !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: y=%0d act=%0b, expected y=620 act=0", bus.y_out, bus.active_out);
    end
    step();
    rst = 1'b0;
    step();
    run_frames(2);
    checks++;
    if (bus.y_out !== 10'd620 || bus.active_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frozen: y=%0d act=%0b, expected y=620 act=0", bus.y_out, bus.active_out);
    end
  endtask

  task automatic test_miss();
    spawn(4'd10);
    run_frames(62);
    checks++;
    if (bus.y_out !== 10'd0 || bus.state !== SCROLL) begin
      errors++;
      $display("FAIL reach_top: y=%0d state=%0d, expected y=0 SCROLL", bus.y_out, bus.state);
    end
    exp_q.push_back({1'b0, 1'b1, exp_grade, 10'd0});
    frame();
    checks++;
    if (bus.y_out !== 10'd0 || bus.active_out !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL after_miss: y=%0d act=%0b state=%0d, expected y=0 act=0 IDLE",
               bus.y_out, bus.active_out, bus.state);
    end
  endtask

  task automatic test_perfect_hold();
    spawn(4'd12);
    run_frames(48);
    checks++;
    if (bus.y_out !== 10'd44) begin
      errors++;
      $display("FAIL approach_44: y=%0d, expected 44", bus.y_out);
    end
    push_hit(2'd2, 10'd44);
    press();
    for (int i = 1; i <= 8; i++) begin
      frame();
      if (i == 1) spawn(4'd5);
      checks++;
      if (i < 8 && (bus.y_out !== 10'd44 || bus.active_out !== 1'b1 || bus.state !== HOLD)) begin
        errors++;
        $display("FAIL hold_frame_%0d: y=%0d act=%0b state=%0d, expected y=44 act=1 HOLD",
                 i, bus.y_out, bus.active_out, bus.state);
      end else if (i == 8 && (bus.y_out !== 10'd44 || bus.active_out !== 1'b0 ||
                              bus.state !== IDLE || bus.grade_out !== 2'd2)) begin
        errors++;
        $display("FAIL hold_end: y=%0d act=%0b state=%0d grade=%0d, expected y=44 act=0 IDLE grade=2",
                 bus.y_out, bus.active_out, bus.state, bus.grade_out);
      end
    end
  endtask

  task automatic test_good_hit();
    spawn(4'd2);
    run_frames(283);
    push_hit(2'd1, 10'd54);
    press();
    checks++;
    if (bus.y_out !== 10'd54 || bus.state !== HOLD) begin
      errors++;
      $display("FAIL good_hit: y=%0d state=%0d, expected y=54 HOLD", bus.y_out, bus.state);
    end
    run_frames(8);
  endtask

  task automatic test_ignored_and_coincident();
    spawn(4'd10);
    run_frames(54);
    press();
    frame();
    checks++;
    if (bus.y_out !== 10'd70 || bus.state !== SCROLL) begin
      errors++;
      $display("FAIL far_press: y=%0d state=%0d, expected y=70 SCROLL", bus.y_out, bus.state);
    end
    frame(1'b1);
    checks++;
    if (bus.y_out !== 10'd60 || bus.state !== SCROLL) begin
      errors++;
      $display("FAIL far_press_tick: y=%0d state=%0d, expected y=60 SCROLL", bus.y_out, bus.state);
    end
    frame();
    push_hit(2'd1, 10'd50);
    frame(1'b1);
    checks++;
    if (bus.y_out !== 10'd50 || bus.state !== HOLD) begin
      errors++;
      $display("FAIL coincident_hit: y=%0d state=%0d, expected y=50 HOLD", bus.y_out, bus.state);
    end
    run_frames(8);
  endtask

  task automatic test_speed_zero_and_tick_spawn();
    logic [9:0] ey;
    spawn(4'd0);
    ey = 10'd620;
    for (int i = 0; i < 3; i++) begin
      frame();
      ey = ey - 10'd1;
      checks++;
      if (bus.y_out !== ey) begin
        errors++;
        $display("FAIL speed0_step: y=%0d, expected %0d", bus.y_out, ey);
      end
    end
    bus.hcount_in = 11'd1; bus.vcount_in = 10'd720; step();
    bus.hcount_in = 11'd0; bus.vcount_in = 10'd719; step();
    idle_inputs(); step(); step();
    checks++;
    if (bus.y_out !== 10'd617) begin
      errors++;
      $display("FAIL near_tick_coords: y=%0d, expected 617", bus.y_out);
    end
    rst = 1'b1; step(); rst = 1'b0; step();
    bus.hcount_in = 11'd0; bus.vcount_in = 10'd720; step();
    idle_inputs();
    spawn(4'd3);
    step();
    checks++;
    if (bus.y_out !== 10'd620 || bus.state !== SCROLL) begin
      errors++;
      $display("FAIL tick_spawn: y=%0d state=%0d, expected y=620 SCROLL", bus.y_out, bus.state);
    end
    frame();
    checks++;
    if (bus.y_out !== 10'd617) begin
      errors++;
      $display("FAIL tick_spawn_move: y=%0d, expected 617", bus.y_out);
    end
  endtask

  initial begin
    bus.spawn_in = 1'b0;
    bus.speed_in = 4'd0;
    bus.hit_in   = 1'b0;
    idle_inputs();
    test_reset();
    test_scroll();
    test_reset_mid_scroll();
    test_miss();
    test_perfect_hold();
    test_good_hit();
    test_ignored_and_coincident();
    test_speed_zero_and_tick_spawn();
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arrow_scroll_ctrl.md
Name: arrow_scroll_ctrl

Overview:
- Position controller directly upstream of the arrow sprite renderer.
- Spawns an arrow at the bottom of the lane, scrolls it upward once per frame, and grades player hits against a target band.
- Drives the sprite's x/y inputs and gives the sprite an active flag.
- Updates position only on a once-per-frame tick in vertical blanking, so a sprite is never torn mid-frame.

Parameters:
- X_POS, 590, fixed lane x coordinate driven on x_out (11 bits).
- START_Y, 620, y loaded on spawn (720 - SPRITE_H).
- TARGET_Y, 40, centre of the hit band.
- WINDOW, 16, half-width of the "good" band; "perfect" is |dy| <= WINDOW/4.
- HOLD_FRAMES, 8, frames the arrow stays frozen and visible after a hit.
- TICK_LINE, 720, vcount on which the frame tick fires (first blanking line).

Ports:
- pixel_clk_in, input, 1, pixel clock.
- rst_in, input, 1, asynchronous active-high reset.
- hcount_in, input, 11, current pixel column from the video timing generator.
- vcount_in, input, 10, current line from the video timing generator.
- spawn_in, input, 1, single-cycle request to launch an arrow.
- speed_in, input, 4, pixels per frame to move; sampled at spawn.
- hit_in, input, 1, single-cycle player press for this lane.
- x_out, output, 11, sprite x; constant X_POS.
- y_out, output, 10, sprite y.
- active_out, output, 1, high while the arrow should be drawn.
- hit_out, output, 1, single-cycle pulse on a graded hit.
- grade_out, output, 2, 0 none, 1 good, 2 perfect; valid with hit_out and held until the next hit_out.
- miss_out, output, 1, single-cycle pulse when the arrow leaves the top unhit.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - x_out=X_POS, y_out=START_Y, active_out=0, hit_out=0, grade_out=0, miss_out=0.
  - Latched speed=0, hold counter=0.
- Frame tick:
  - tick is a registered one-cycle pulse, asserted the cycle after hcount_in==0 && vcount_in==TICK_LINE.
  - Exactly one tick per frame.
- States:
  - IDLE → SCROLL on spawn_in.
    - Loads y_out=START_Y and latches speed_in.
    - speed_in==0 is latched as 1.
    - active_out rises the next cycle.
  - SCROLL, on tick:
    - If y_out < speed, go to IDLE with a one-cycle miss_out pulse; y_out is unchanged and never wraps.
    - Otherwise y_out -= speed.
  - SCROLL, on hit_in, with dy = |y_out - TARGET_Y| computed in 11-bit unsigned after ordering the operands:
    - dy <= WINDOW/4: grade 2.
    - dy <= WINDOW: grade 1.
    - In either graded case: hit_out pulses one cycle, go to HOLD, hold counter=HOLD_FRAMES.
    - dy > WINDOW: press ignored, no output, stay in SCROLL.
  - HOLD:
    - y_out frozen, active_out=1.
    - Counter decrements on each tick; at 0, go to IDLE.
- active_out:
  - 1 in SCROLL and HOLD.
  - 0 in IDLE, from the cycle after the IDLE transition.
- Simultaneous events:
  - spawn_in outside IDLE is ignored.
  - spawn_in with tick in IDLE: enter SCROLL; the first move is on the next tick.
  - hit_in with tick in SCROLL: the hit is graded on the pre-tick y_out. A graded hit suppresses the move and any miss; an ungraded press leaves the tick action intact.
  - hit_in in IDLE or HOLD is ignored.
- Latency:
  - hit_in/tick to hit_out/miss_out/y_out change: 1 cycle, all registered.
  - y_out changes only in blanking, so the renderer's pipeline latency is irrelevant.

Decomposition:
- Shared package arrow_pkg holds:
  - state enum {IDLE, SCROLL, HOLD}.
  - grade enum {GRADE_NONE, GRADE_GOOD, GRADE_PERFECT}.
  - Screen constants SCREEN_H=720 and SPRITE_H=100.
- Sub-module frame_tick_gen (hcount/vcount → registered tick), reused by other per-frame controllers.

Test Plan:
- Reset during SCROLL with y_out=300 → y_out=620, active_out=0 with no clock edge; the following ticks leave y_out unchanged.
- spawn_in with speed_in=10, then 3 frames → y_out goes 620, 610, 600, 590 on successive ticks; active_out=1.
- speed_in=10, no press until y_out=0:
  - The next tick gives miss_out=1 for one cycle, y_out=0, IDLE.
  - active_out=0 from the following cycle.
- hit_in at y_out=44 (TARGET_Y=40) → hit_out pulse with grade_out=2, then 8 ticks frozen at 44, then active_out=0.
- hit_in at y_out=54 → grade 1. A separate run with hit_in at y_out=80 → no output and scrolling continues.
- hit_in coincident with tick at y_out=50 → grade 1, y_out stays 50. spawn_in during HOLD is ignored. spawn_in with speed_in=0 moves 1 px per frame.
